rate_recovery: RTL and testbench
================================

// Module: rate_recovery
// PURPOSE
//  Receive-side partner of the clock generator. Watches a synchronized incoming IO clock level,
//  measures the half-period in sys cycles and locks once enough consecutive measurements agree.
//  Then drives the expected_half_rate_minus_two / expected_quarter_rate_minus_one values that
//  feed the generator, plus per-edge rise/fall pulses for skew/early-edge recovery.
// PARAMETERS
//  RATE_W   default clks_alot_p::RATE_COUNTER_WIDTH (16)  width of rate counters/outputs
//  LOCK_W   default 4                                     width of lock-in/mismatch/timeout counters
// PORTS
//  sys_dom_i               input   common_p::clk_dom_s  .clk system clock; .sync_rst sync active-high reset
//  io_clk_i                input   1       IO clock level, already synchronized to sys_dom_i.clk
//  recovery_en_i           input   1       0 = IDLE, clears lock and fault
//  drift_window_i          input   RATE_W  max |measured-candidate| still counted as a match
//  lockin_count_i          input   LOCK_W  consecutive matches needed to lock (0 treated as 1)
//  lockin_timeout_i        input   LOCK_W  edges allowed in ACQUIRE before fault (0 = no timeout)
//  io_rise_o               output  1       1-cycle pulse, rising edge detected
//  io_fall_o               output  1       1-cycle pulse, falling edge detected
//  locked_o                output  1       state == LOCKED
//  half_rate_minus_two_o   output  RATE_W  locked half-period minus 2
//  quarter_rate_minus_one_o output RATE_W  (half-period>>1) minus 1, floor 0
//  lock_lost_o             output  1       1-cycle pulse on LOCKED -> ACQUIRE
//  lockin_violation_o      output  1       sticky while in FAULT
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; prev_level, counters, candidate, rate regs 0.
//  Edge detect: prev_level <= io_clk_i every cycle; rise = io & ~prev, fall = ~io & prev;
//   io_rise_o/io_fall_o registered, so 1 cycle after the changed sample.
//  Period counter: +1 per cycle, saturates at all-ones; on any edge measured = cnt+1, cnt <= 0.
//   Saturation reached (no edge) in ACQUIRE clears match count; in LOCKED forces lock loss.
//  Match: |measured - candidate| <= drift_window_i, compare done in RATE_W+1 bits; measured < 2
//   never matches (too fast for generator).
//  FSM (evaluated on edges unless noted):
//   IDLE: recovery_en_i=1 -> ACQUIRE; candidate/match/timeout counters cleared.
//   ACQUIRE: match -> match_cnt+1; else candidate <= measured, match_cnt <= 0.
//    match_cnt+1 == max(lockin_count_i,1) -> LOCKED, rate <= candidate, outputs update same edge.
//    timeout_cnt+1 == lockin_timeout_i (nonzero) without lock -> FAULT. Lock wins if both same edge.
//   LOCKED: match -> mismatch_cnt <= 0; mismatch -> mismatch_cnt+1; reaching max(lockin_count_i,1)
//    or counter saturation -> ACQUIRE, lock_lost_o pulse, candidate <= measured, outputs held.
//   FAULT: lockin_violation_o=1; leaves only via recovery_en_i=0 (-> IDLE).
//   recovery_en_i=0 in any state -> IDLE next cycle; locked_o/rate outputs cleared.
//  sync_rst mid-operation: immediate return to reset values next cycle, no pulses.
//  Rate outputs change only on lock entry (or drift step below); stable otherwise.
// CONFIGURATION
//  CLKS_ALOT_DRIFT_TRACK_EN defined: in LOCKED a matching measurement != rate steps rate by +-1
//   toward measured (once per edge); outputs follow next cycle.
//  Not defined: rate frozen from lock entry until lock loss/IDLE.
// TESTING
//  1 en=1, lockin=3, window=0, io half-period 10 cycles -> locked_o after 4th edge, half=8, quarter=4.
//  2 locked @10, insert one 14-cycle half-period, window=1 -> mismatch_cnt=1, stays locked, next 10 clears.
//  3 locked @10, lockin=3, three 20-cycle periods -> lock_lost_o single pulse, locked_o=0, ACQUIRE.
//  4 timeout=5, alternating 10/30 periods -> lockin_violation_o=1 after 5th edge; en=0 -> cleared.
//  5 DRIFT_TRACK_EN, window=2, locked @10, periods of 12 -> half_rate steps 8,9,10 then holds.
//  6 sync_rst pulsed while LOCKED -> all outputs 0 next cycle, relock needs full lockin sequence.

Source files
------------

// File: rtl/rate_recovery.sv
// -----------------------------------------------------------------------------
// rate_recovery
//   Receive-side partner of the clock generator. It watches an incoming IO clock
//   level that is already synchronised to clk. It measures each half-period in
//   clk cycles and locks once enough consecutive measurements agree. While
//   locked it drives the half-rate-minus-two and quarter-rate-minus-one values
//   that the generator consumes. It also emits per-edge rise/fall pulses, which
//   are used for skew and early-edge recovery.
//
//   Optional feature macro: CLKS_ALOT_DRIFT_TRACK_EN
//     Defined : while LOCKED, a matching measurement that differs from the
//               locked rate moves the rate one step (+1 or -1) toward it on
//               each edge.
//     Undefined: the rate is frozen from lock entry until lock loss or IDLE.
//
// Ports
//   clk                     system clock
//   sync_rst                synchronous active-high reset
//   io_clk                  IO clock level, synchronous to clk
//   recovery_en             0 forces IDLE (clears lock and fault)
//   drift_window            max |measured - candidate| still counted as a match
//   lockin_count            consecutive matches needed to lock (0 acts as 1)
//   lockin_timeout          edges allowed in ACQUIRE before fault (0 = never)
//   io_rise / io_fall       1-cycle pulses, one cycle after the changed sample
//   locked                  high while locked
//   half_rate_minus_two     locked half-period minus 2
//   quarter_rate_minus_one  (half-period >> 1) minus 1, floor 0
//   lock_lost               1-cycle pulse on LOCKED -> ACQUIRE
//   lockin_violation        high while in FAULT
// -----------------------------------------------------------------------------
module rate_recovery #(
  parameter int RATE_W = 16,
  parameter int LOCK_W = 4
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              io_clk,
  input  logic              recovery_en,
  input  logic [RATE_W-1:0] drift_window,
  input  logic [LOCK_W-1:0] lockin_count,
  input  logic [LOCK_W-1:0] lockin_timeout,
  output logic              io_rise,
  output logic              io_fall,
  output logic              locked,
  output logic [RATE_W-1:0] half_rate_minus_two,
  output logic [RATE_W-1:0] quarter_rate_minus_one,
  output logic              lock_lost,
  output logic              lockin_violation
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t            state_reg, state_next;
  logic              prev_level_reg;
  logic              rise_reg, fall_reg;
  logic [RATE_W-1:0] period_cnt_reg, period_cnt_next;
  logic [RATE_W-1:0] candidate_reg, candidate_next;
  logic [RATE_W-1:0] rate_reg, rate_next;
  logic [RATE_W-1:0] half_reg, half_next;
  logic [RATE_W-1:0] quarter_reg, quarter_next;
  logic [LOCK_W-1:0] match_cnt_reg, match_cnt_next;
  logic [LOCK_W-1:0] mismatch_cnt_reg, mismatch_cnt_next;
  logic [LOCK_W-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic              lock_lost_reg, lock_lost_next;

  // Edge detection and half-period measurement
  logic              rise_det, fall_det, edge_det, cnt_sat, is_match;
  logic [RATE_W-1:0] measured, rate_half;
  logic [RATE_W:0]   meas_ext, cand_ext, abs_diff;
  logic [LOCK_W-1:0] lock_target, match_inc, mismatch_inc, timeout_inc;

  assign rise_det = io_clk & ~prev_level_reg;
  assign fall_det = ~io_clk & prev_level_reg;
  assign edge_det = rise_det | fall_det;
  assign cnt_sat  = &period_cnt_reg;

  // The counter holds (cycles since last edge - 1), so the half-period is cnt+1.
  // Once saturated, the measurement is pinned at all-ones instead of wrapping.
  assign measured = cnt_sat ? period_cnt_reg : period_cnt_reg + RATE_W'(1);

  always_comb begin
    period_cnt_next = period_cnt_reg;
    if (edge_det)
      period_cnt_next = '0;
    else if (!cnt_sat)
      period_cnt_next = period_cnt_reg + RATE_W'(1);
  end

  // The absolute difference is taken one bit wider so that the subtraction
  // never wraps.
  assign meas_ext = {1'b0, measured};
  assign cand_ext = {1'b0, candidate_reg};
  assign abs_diff = (meas_ext >= cand_ext) ? (meas_ext - cand_ext) : (cand_ext - meas_ext);
  // Half-periods shorter than 2 cycles are too fast for the generator.
  assign is_match = (measured >= RATE_W'(2)) && (abs_diff <= {1'b0, drift_window});

  assign lock_target  = (lockin_count == '0) ? LOCK_W'(1) : lockin_count;
  assign match_inc    = match_cnt_reg + LOCK_W'(1);
  assign mismatch_inc = mismatch_cnt_reg + LOCK_W'(1);
  assign timeout_inc  = (&timeout_cnt_reg) ? timeout_cnt_reg : timeout_cnt_reg + LOCK_W'(1);

  // FSM next-state and datapath updates
  logic lose_lock;

  always_comb begin
    state_next        = state_reg;
    candidate_next    = candidate_reg;
    rate_next         = rate_reg;
    match_cnt_next    = match_cnt_reg;
    mismatch_cnt_next = mismatch_cnt_reg;
    timeout_cnt_next  = timeout_cnt_reg;
    lock_lost_next    = 1'b0;
    lose_lock         = 1'b0;

    case (state_reg)
      IDLE: begin
        candidate_next    = '0;
        rate_next         = '0;
        match_cnt_next    = '0;
        mismatch_cnt_next = '0;
        timeout_cnt_next  = '0;
        if (recovery_en)
          state_next = ACQUIRE;
      end

      ACQUIRE: begin
        if (edge_det) begin
          timeout_cnt_next = timeout_inc;
          if (is_match) begin
            match_cnt_next = match_inc;
            if (match_inc == lock_target) begin
              state_next        = LOCKED;
              rate_next         = candidate_reg;
              mismatch_cnt_next = '0;
            end
          end else begin
            candidate_next = measured;
            match_cnt_next = '0;
          end
          // If lock and timeout happen on the same edge, lock takes priority.
          if (state_next != LOCKED && lockin_timeout != '0 && timeout_inc == lockin_timeout)
            state_next = FAULT;
        end else if (cnt_sat) begin
          match_cnt_next = '0;
        end
      end

      LOCKED: begin
        if (edge_det) begin
          if (is_match) begin
            mismatch_cnt_next = '0;
`ifdef CLKS_ALOT_DRIFT_TRACK_EN
            if (measured > rate_reg)
              rate_next = rate_reg + RATE_W'(1);
            else if (measured < rate_reg)
              rate_next = rate_reg - RATE_W'(1);
`endif
          end else begin
            mismatch_cnt_next = mismatch_inc;
            if (mismatch_inc == lock_target)
              lose_lock = 1'b1;
          end
        end else if (cnt_sat) begin
          lose_lock = 1'b1;
        end
        // The rate outputs keep their last locked value until the next lock.
        if (lose_lock) begin
          state_next        = ACQUIRE;
          lock_lost_next    = 1'b1;
          candidate_next    = measured;
          match_cnt_next    = '0;
          mismatch_cnt_next = '0;
          timeout_cnt_next  = '0;
        end
      end

      FAULT: ;

      default: state_next = IDLE;
    endcase

    // Disabling overrides everything and clears the lock outputs.
    if (!recovery_en) begin
      state_next     = IDLE;
      rate_next      = '0;
      lock_lost_next = 1'b0;
    end
  end

  // Generator-facing values are saturated so that tiny rates never wrap.
  assign rate_half = rate_next >> 1;
  assign half_next    = (rate_next < RATE_W'(2)) ? '0 : rate_next - RATE_W'(2);
  assign quarter_next = (rate_half == '0) ? '0 : rate_half - RATE_W'(1);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_reg        <= IDLE;
      prev_level_reg   <= 1'b0;
      rise_reg         <= 1'b0;
      fall_reg         <= 1'b0;
      period_cnt_reg   <= '0;
      candidate_reg    <= '0;
      rate_reg         <= '0;
      half_reg         <= '0;
      quarter_reg      <= '0;
      match_cnt_reg    <= '0;
      mismatch_cnt_reg <= '0;
      timeout_cnt_reg  <= '0;
      lock_lost_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      prev_level_reg   <= io_clk;
      rise_reg         <= rise_det;
      fall_reg         <= fall_det;
      period_cnt_reg   <= period_cnt_next;
      candidate_reg    <= candidate_next;
      rate_reg         <= rate_next;
      half_reg         <= half_next;
      quarter_reg      <= quarter_next;
      match_cnt_reg    <= match_cnt_next;
      mismatch_cnt_reg <= mismatch_cnt_next;
      timeout_cnt_reg  <= timeout_cnt_next;
      lock_lost_reg    <= lock_lost_next;
    end
  end

  assign io_rise                = rise_reg;
  assign io_fall                = fall_reg;
  assign locked                 = (state_reg == LOCKED);
  assign lockin_violation       = (state_reg == FAULT);
  assign half_rate_minus_two    = half_reg;
  assign quarter_rate_minus_one = quarter_reg;
  assign lock_lost              = lock_lost_reg;

endmodule

// File: tb/tb_rate_recovery.sv
// -----------------------------------------------------------------------------
// tb_rate_recovery
//   Directed bench for rate_recovery. Each IO toggle pushes the expected
//   rise/fall pulse (kind and cycle) into a queue. A monitor pops the queue when
//   a pulse appears. Lock, rate, loss and fault behaviour is checked at fixed
//   points in the stimulus.
// -----------------------------------------------------------------------------
module tb_rate_recovery;

  localparam int RATE_W = 16;
  localparam int LOCK_W = 4;
`ifdef CLKS_ALOT_DRIFT_TRACK_EN
  localparam bit DRIFT = 1'b1;
`else
  localparam bit DRIFT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              sync_rst;
  logic              io_clk;
  logic              recovery_en;
  logic [RATE_W-1:0] drift_window;
  logic [LOCK_W-1:0] lockin_count;
  logic [LOCK_W-1:0] lockin_timeout;
  logic              io_rise, io_fall, locked, lock_lost, lockin_violation;
  logic [RATE_W-1:0] half_rate_minus_two, quarter_rate_minus_one;

  rate_recovery #(.RATE_W(RATE_W), .LOCK_W(LOCK_W)) dut (
    .clk                    (clk),
    .sync_rst               (sync_rst),
    .io_clk                 (io_clk),
    .recovery_en            (recovery_en),
    .drift_window           (drift_window),
    .lockin_count           (lockin_count),
    .lockin_timeout         (lockin_timeout),
    .io_rise                (io_rise),
    .io_fall                (io_fall),
    .locked                 (locked),
    .half_rate_minus_two    (half_rate_minus_two),
    .quarter_rate_minus_one (quarter_rate_minus_one),
    .lock_lost              (lock_lost),
    .lockin_violation       (lockin_violation)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int lost_count = 0;

  typedef struct {
    int         cyc;
    logic [1:0] kind;  // 2'b10 rise, 2'b01 fall
  } pulse_t;
  pulse_t pq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle the IO level; its pulse must appear right after the next clock edge.
  task automatic toggle_io();
    pulse_t p;
    io_clk = ~io_clk;
    p.cyc  = cyc + 1;
    p.kind = io_clk ? 2'b10 : 2'b01;
    pq.push_back(p);
  endtask

  // Edge now, then n cycles of stable level (the next edge measures n).
  task automatic half(input int n);
    toggle_io();
    repeat (n) tick();
  endtask

  // From IDLE: one edge to enter ACQUIRE, then four 10-cycle measurements.
  task automatic lock10();
    recovery_en = 1'b1;
    repeat (5) half(10);
  endtask

  // Pulse monitor: checks every rise/fall pulse against the queue.
  always begin
    pulse_t e;
    @(posedge clk);
    #1;
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      chk("pulse_missing_cycle", cyc, pq[0].cyc);
      void'(pq.pop_front());
    end
    if (io_rise || io_fall) begin
      if (pq.size() == 0) begin
        chk("pulse_unexpected", pq.size(), 1);
      end else begin
        e = pq.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", {io_rise, io_fall}, e.kind);
        $display("pulse cyc=%0d rise=%0b fall=%0b", cyc, io_rise, io_fall);
      end
    end
    if (lock_lost) lost_count++;
  end

  initial begin
    sync_rst       = 1'b1;
    io_clk         = 1'b0;
    recovery_en    = 1'b0;
    drift_window   = '0;
    lockin_count   = 4'd3;
    lockin_timeout = '0;
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_half", half_rate_minus_two, 0);
    chk("rst_quarter", quarter_rate_minus_one, 0);
    chk("rst_violation", lockin_violation, 0);
    chk("rst_lost", lock_lost, 0);
    chk("rst_rise", io_rise, 0);
    sync_rst = 1'b0;
    tick();

    // 1: lock on a 10-cycle half-period after the 4th edge in ACQUIRE.
    half(10);
    recovery_en = 1'b1;
    half(10);
    repeat (3) half(10);
    chk("t1_not_yet_locked", locked, 0);
    toggle_io();
    tick();
    chk("t1_locked", locked, 1);
    chk("t1_half", half_rate_minus_two, 8);
    chk("t1_quarter", quarter_rate_minus_one, 4);
    repeat (9) tick();

    // 2: single 14 outlier within lock; the next 10 clears the mismatch count,
    //    so two later 20-cycle mismatches do not drop the lock.
    drift_window = 16'd1;
    half(14);
    half(10);
    half(10);
    chk("t2_locked_after_outlier", locked, 1);
    half(20);
    half(20);
    half(10);
    half(10);
    chk("t2_still_locked", locked, 1);
    chk("t2_half", half_rate_minus_two, 8);
    chk("t2_quarter", quarter_rate_minus_one, 4);

    // 3: three 20-cycle measurements lose the lock.
    drift_window = '0;
    half(20);
    half(20);
    half(20);
    toggle_io();
    tick();
    chk("t3_unlocked", locked, 0);
    chk("t3_lost_pulse", lock_lost, 1);
    chk("t3_half_held", half_rate_minus_two, 8);
    tick();
    chk("t3_lost_single", lock_lost, 0);
    repeat (18) tick();
    recovery_en = 1'b0;
    tick();
    chk("t3_idle_half", half_rate_minus_two, 0);
    chk("t3_idle_quarter", quarter_rate_minus_one, 0);

    // 4: timeout of 5 edges with alternating 10/30 half-periods.
    lockin_timeout = 4'd5;
    recovery_en    = 1'b1;
    tick();
    half(10);
    half(30);
    half(10);
    half(30);
    chk("t4_no_fault_yet", lockin_violation, 0);
    toggle_io();
    tick();
    chk("t4_fault", lockin_violation, 1);
    repeat (29) tick();
    repeat (5) half(10);
    chk("t4_fault_sticky", lockin_violation, 1);
    chk("t4_fault_not_locked", locked, 0);
    recovery_en = 1'b0;
    tick();
    chk("t4_fault_cleared", lockin_violation, 0);
    lockin_timeout = '0;

    // 5: drift window 2, 12-cycle half-periods after locking at 10.
    lock10();
    chk("t5_locked", locked, 1);
    chk("t5_half_initial", half_rate_minus_two, 8);
    drift_window = 16'd2;
    half(12);
    toggle_io();
    tick();
    chk("t5_half_step1", half_rate_minus_two, DRIFT ? 9 : 8);
    repeat (11) tick();
    toggle_io();
    tick();
    chk("t5_half_step2", half_rate_minus_two, DRIFT ? 10 : 8);
    repeat (11) tick();
    toggle_io();
    tick();
    chk("t5_half_hold", half_rate_minus_two, DRIFT ? 10 : 8);
    chk("t5_quarter", quarter_rate_minus_one, DRIFT ? 5 : 4);
    chk("t5_still_locked", locked, 1);
    repeat (11) tick();

    // 6: reset while locked; relock needs the full sequence.
    drift_window = '0;
    sync_rst = 1'b1;
    tick();
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_half", half_rate_minus_two, 0);
    chk("t6_rst_quarter", quarter_rate_minus_one, 0);
    chk("t6_rst_lost", lock_lost, 0);
    tick();
    sync_rst = 1'b0;
    if (io_clk) begin
      pulse_t p;
      p.cyc  = cyc + 1;
      p.kind = 2'b10;
      pq.push_back(p);
    end
    tick();
    repeat (4) half(10);
    chk("t6_not_yet_locked", locked, 0);
    toggle_io();
    tick();
    chk("t6_relocked", locked, 1);
    chk("t6_half", half_rate_minus_two, 8);
    repeat (9) tick();

    repeat (3) tick();
    chk("pulse_queue_empty", pq.size(), 0);
    chk("lock_lost_total", lost_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
